if_id_stage_buffer: RTL and testbench
=====================================

// Module: if_id_stage_buffer
// PURPOSE
//  Two-entry elastic pipeline buffer between the IF datapath and the ID stage.
//  Captures fetched instruction, PC and PC+4 with a valid/ready handshake on both sides.
//  Absorbs one cycle of ID back-pressure without losing a fetched instruction.
//  Discards all held and incoming instructions on a redirect (flush_i).
// PARAMETERS
//  INST_WIDTH       32            instruction width
//  INST_ADDR_WIDTH  32            PC / PC+4 width
//  NOP_INST         32'h00000013  bubble (addi x0,x0,0) shown on ID_inst_o when empty
// PORTS
//  clk             in   1                clock, rising edge
//  rst_n           in   1                asynchronous active-low reset
//  flush_i         in   1                redirect: drop buffer contents and same-cycle input
//  IF_valid_i      in   1                IF presents a valid instruction
//  IF_ready_o      out  1                buffer can accept (registered)
//  IF_inst_i       in   INST_WIDTH       fetched instruction
//  IF_PC_i         in   INST_ADDR_WIDTH  PC of the instruction
//  IF_PC_plus_4_i  in   INST_ADDR_WIDTH  PC+4 of the instruction
//  ID_valid_o      out  1                head entry valid
//  ID_ready_i      in   1                ID consumes the head this cycle
//  ID_inst_o       out  INST_WIDTH       head instruction, NOP_INST when empty
//  ID_PC_o         out  INST_ADDR_WIDTH  head PC, 0 when empty
//  ID_PC_plus_4_o  out  INST_ADDR_WIDTH  head PC+4, 0 when empty
//  count_o         out  2                occupancy 0..2
// BEHAVIOUR
//  - Reset (rst_n=0, async): count=0, rd/wr pointers=0, IF_ready_o=1, ID_valid_o=0,
//    ID_inst_o=NOP_INST, ID_PC_o=0, ID_PC_plus_4_o=0. Entry storage need not be cleared.
//  - push = IF_valid_i & IF_ready_o & ~flush_i; pop = ID_valid_o & ID_ready_i & ~flush_i.
//  - Storage: 2-entry circular buffer, 1-bit wr_ptr/rd_ptr, wrap 1->0.
//  - count_next: flush -> 0; push&~pop -> +1; pop&~push -> -1; else unchanged.
//  - IF_ready_o = (count != 2), driven from the registered count; never depends on ID_ready_i.
//  - ID_valid_o = (count != 0); ID_* outputs are head entry contents, combinational from
//    registered state only. Latency: IF capture at edge N -> visible on ID_* after edge N.
//  - Empty: ID_inst_o=NOP_INST, PCs=0, ID_ready_i ignored.
//  - Full (count=2): IF_ready_o=0; a simultaneous pop frees one slot, visible next cycle.
//  - Push+pop same cycle with count=1: count stays 1, head advances to the new entry.
//  - flush_i has priority over push and pop: count->0, pointers->0; no entry appears on
//    ID the next cycle even if IF_valid_i=1 during the flush.
//  - Head must stay stable while ID_valid_o=1 and ID_ready_i=0.
//  - Ordering strictly FIFO; no entry duplicated or dropped except by flush/reset.
//  - Reset asserted mid-operation discards all entries immediately (async).
// TESTING
//  1 Reset: rst_n=0 -> ID_valid_o=0, ID_inst_o=32'h13, IF_ready_o=1, count_o=0.
//  2 Streaming: ID_ready_i=1, IF PC=0,4,8 one per cycle -> ID shows same PCs one cycle
//    later, PC_plus_4 = 4,8,12, count_o stays 1.
//  3 Back-pressure: ID_ready_i=0, push PC=0x100,0x104 -> count_o=2, IF_ready_o=0,
//    ID_PC_o holds 0x100; release ID_ready_i -> 0x100 then 0x104 delivered in order.
//  4 Full + pop: count=2, ID_ready_i=1, IF_valid_i=1 -> no push that cycle; next cycle
//    IF_ready_o=1, count_o=1.
//  5 Flush: count=2, flush_i=1 with IF_valid_i=1 PC=0x200 -> next cycle count_o=0,
//    ID_valid_o=0, ID_inst_o=32'h13; 0x200 never appears on ID.
//  6 Async reset mid-stream: drop rst_n between edges with count=2 -> outputs reset
//    immediately; PC sequence after release restarts cleanly with no stale entries.

Source files
------------

// File: rtl/if_id_stage_buffer.sv
// Two-entry elastic buffer between the IF datapath and the ID stage.
// Holds instruction, PC and PC+4 with valid/ready on both sides; flush_i discards everything.
module if_id_stage_buffer #(
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned INST_ADDR_WIDTH = 32,
  parameter logic [INST_WIDTH-1:0] NOP_INST = INST_WIDTH'(32'h00000013)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       IF_valid_i,
  output logic                       IF_ready_o,
  input  logic [INST_WIDTH-1:0]      IF_inst_i,
  input  logic [INST_ADDR_WIDTH-1:0] IF_PC_i,
  input  logic [INST_ADDR_WIDTH-1:0] IF_PC_plus_4_i,
  output logic                       ID_valid_o,
  input  logic                       ID_ready_i,
  output logic [INST_WIDTH-1:0]      ID_inst_o,
  output logic [INST_ADDR_WIDTH-1:0] ID_PC_o,
  output logic [INST_ADDR_WIDTH-1:0] ID_PC_plus_4_o,
  output logic [1:0]                 count_o
);

  logic [1:0] count_q, count_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;

  logic [INST_WIDTH-1:0]      inst_q [2];
  logic [INST_WIDTH-1:0]      inst_d [2];
  logic [INST_ADDR_WIDTH-1:0] pc_q [2];
  logic [INST_ADDR_WIDTH-1:0] pc_d [2];
  logic [INST_ADDR_WIDTH-1:0] pc4_q [2];
  logic [INST_ADDR_WIDTH-1:0] pc4_d [2];

  logic push, pop;

  // Handshake flags come only from registered count, so IF never sees ID_ready_i.
  assign IF_ready_o = (count_q != 2'd2);
  assign ID_valid_o = (count_q != 2'd0);
  assign count_o    = count_q;

  assign push = IF_valid_i & IF_ready_o & ~flush_i;
  assign pop  = ID_valid_o & ID_ready_i & ~flush_i;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    inst_d   = inst_q;
    pc_d     = pc_q;
    pc4_d    = pc4_q;

    if (flush_i) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) begin
        inst_d[wr_ptr_q] = IF_inst_i;
        pc_d[wr_ptr_q]   = IF_PC_i;
        pc4_d[wr_ptr_q]  = IF_PC_plus_4_i;
        wr_ptr_d         = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      if (push && !pop) begin
        count_d = count_q + 2'd1;
      end else if (pop && !push) begin
        count_d = count_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Payload storage is qualified by count, so it needs no reset.
  always_ff @(posedge clk) begin
    inst_q <= inst_d;
    pc_q   <= pc_d;
    pc4_q  <= pc4_d;
  end

  assign ID_inst_o      = ID_valid_o ? inst_q[rd_ptr_q] : NOP_INST;
  assign ID_PC_o        = ID_valid_o ? pc_q[rd_ptr_q]   : '0;
  assign ID_PC_plus_4_o = ID_valid_o ? pc4_q[rd_ptr_q]  : '0;

endmodule

// File: tb/tb_if_id_stage_buffer.sv
// Directed bench for if_id_stage_buffer: reset, streaming, back-pressure, full+pop,
// flush and asynchronous reset, with hand-computed expected values.
module tb_if_id_stage_buffer;

  logic        clk;
  logic        rst_n;
  logic        flush_i;
  logic        IF_valid_i;
  logic        IF_ready_o;
  logic [31:0] IF_inst_i;
  logic [31:0] IF_PC_i;
  logic [31:0] IF_PC_plus_4_i;
  logic        ID_valid_o;
  logic        ID_ready_i;
  logic [31:0] ID_inst_o;
  logic [31:0] ID_PC_o;
  logic [31:0] ID_PC_plus_4_o;
  logic [1:0]  count_o;

  int n_chk;
  int n_fail;

  if_id_stage_buffer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_i        (flush_i),
    .IF_valid_i     (IF_valid_i),
    .IF_ready_o     (IF_ready_o),
    .IF_inst_i      (IF_inst_i),
    .IF_PC_i        (IF_PC_i),
    .IF_PC_plus_4_i (IF_PC_plus_4_i),
    .ID_valid_o     (ID_valid_o),
    .ID_ready_i     (ID_ready_i),
    .ID_inst_o      (ID_inst_o),
    .ID_PC_o        (ID_PC_o),
    .ID_PC_plus_4_o (ID_PC_plus_4_o),
    .count_o        (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Instruction word tagged with its PC so ordering is visible in the payload too.
  task automatic drive(input logic vld, input logic [31:0] pc, input logic rdy, input logic fl);
    IF_valid_i     = vld;
    IF_PC_i        = pc;
    IF_PC_plus_4_i = pc + 32'd4;
    IF_inst_i      = 32'hA5000000 | pc;
    ID_ready_i     = rdy;
    flush_i        = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_cnt"},   32'(count_o),    32'd0);
    chk({tag, "_vld"},   32'(ID_valid_o), 32'd0);
    chk({tag, "_inst"},  ID_inst_o,       32'h00000013);
    chk({tag, "_pc"},    ID_PC_o,         32'd0);
    chk({tag, "_pc4"},   ID_PC_plus_4_o,  32'd0);
    chk({tag, "_rdy"},   32'(IF_ready_o), 32'd1);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);

    // 1 reset
    #3;
    chk_empty("rst");
    #9 rst_n = 1'b1;
    tick();
    chk_empty("post_rst");

    // 2 streaming
    drive(1'b1, 32'h0, 1'b1, 1'b0);
    tick();
    chk("s0_cnt", 32'(count_o), 32'd1);
    chk("s0_pc", ID_PC_o, 32'h0);
    chk("s0_pc4", ID_PC_plus_4_o, 32'h4);
    chk("s0_inst", ID_inst_o, 32'hA5000000);
    drive(1'b1, 32'h4, 1'b1, 1'b0);
    tick();
    chk("s1_cnt", 32'(count_o), 32'd1);
    chk("s1_pc", ID_PC_o, 32'h4);
    chk("s1_pc4", ID_PC_plus_4_o, 32'h8);
    drive(1'b1, 32'h8, 1'b1, 1'b0);
    tick();
    chk("s2_cnt", 32'(count_o), 32'd1);
    chk("s2_pc", ID_PC_o, 32'h8);
    chk("s2_pc4", ID_PC_plus_4_o, 32'hC);
    chk("s2_inst", ID_inst_o, 32'hA5000008);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    chk_empty("s_drain");

    // 3 back-pressure
    drive(1'b1, 32'h100, 1'b0, 1'b0);
    tick();
    chk("bp0_cnt", 32'(count_o), 32'd1);
    chk("bp0_pc", ID_PC_o, 32'h100);
    drive(1'b1, 32'h104, 1'b0, 1'b0);
    tick();
    chk("bp1_cnt", 32'(count_o), 32'd2);
    chk("bp1_rdy", 32'(IF_ready_o), 32'd0);
    chk("bp1_pc", ID_PC_o, 32'h100);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    chk("bp2_hold_pc", ID_PC_o, 32'h100);
    chk("bp2_hold_inst", ID_inst_o, 32'hA5000100);
    chk("bp2_cnt", 32'(count_o), 32'd2);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    chk("bp3_cnt", 32'(count_o), 32'd1);
    chk("bp3_pc", ID_PC_o, 32'h104);
    chk("bp3_pc4", ID_PC_plus_4_o, 32'h108);
    chk("bp3_rdy", 32'(IF_ready_o), 32'd1);
    tick();
    chk_empty("bp_drain");

    // 4 full + pop, IF offer refused while full
    drive(1'b1, 32'h300, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h304, 1'b0, 1'b0);
    tick();
    chk("fp0_cnt", 32'(count_o), 32'd2);
    drive(1'b1, 32'h308, 1'b1, 1'b0);
    tick();
    chk("fp1_cnt", 32'(count_o), 32'd1);
    chk("fp1_rdy", 32'(IF_ready_o), 32'd1);
    chk("fp1_pc", ID_PC_o, 32'h304);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    chk_empty("fp_drain");

    // 5 flush while full, with IF presenting 0x200
    drive(1'b1, 32'h400, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h404, 1'b0, 1'b0);
    tick();
    chk("fl0_cnt", 32'(count_o), 32'd2);
    drive(1'b1, 32'h200, 1'b0, 1'b1);
    tick();
    chk_empty("fl1");
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    chk_empty("fl2");

    // flush at count=1 while IF is ready: the offered entry must be dropped
    drive(1'b1, 32'h500, 1'b0, 1'b0);
    tick();
    chk("fl3_cnt", 32'(count_o), 32'd1);
    drive(1'b1, 32'h204, 1'b1, 1'b1);
    tick();
    chk_empty("fl4");
    drive(1'b1, 32'h600, 1'b0, 1'b0);
    tick();
    chk("fl5_pc", ID_PC_o, 32'h600);
    chk("fl5_cnt", 32'(count_o), 32'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    chk_empty("fl_drain");

    // 6 asynchronous reset between edges with the buffer full
    drive(1'b1, 32'h700, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h704, 1'b0, 1'b0);
    tick();
    chk("ar0_cnt", 32'(count_o), 32'd2);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_empty("ar1");
    #3 rst_n = 1'b1;
    drive(1'b1, 32'h800, 1'b1, 1'b0);
    tick();
    chk("ar2_cnt", 32'(count_o), 32'd1);
    chk("ar2_pc", ID_PC_o, 32'h800);
    chk("ar2_pc4", ID_PC_plus_4_o, 32'h804);
    drive(1'b1, 32'h804, 1'b1, 1'b0);
    tick();
    chk("ar3_pc", ID_PC_o, 32'h804);
    chk("ar3_cnt", 32'(count_o), 32'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    chk_empty("ar_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
